writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Write-back stage plus architectural register file of the pipelined Y86-64 core.
//  - Consumes the W pipeline-register outputs.
//  - Commits valE/valM to the 15 program registers.
//  - Serves the two combinational decode read ports.
//  - Latches the processor status (AOK/HLT/ADR/INS) and counts retired instructions.
// PARAMETERS
//  DATA_W   64   register / value width
//  CNT_W    32   retired-instruction counter width
// PORTS
//  clk          in   1       core clock; all state updates on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  W_stat       in   3       status of instruction in W (0=BUB,1=AOK,2=HLT,3=ADR,4=INS)
//  W_icode      in   4       icode of instruction in W
//  W_valE       in   DATA_W  ALU result
//  W_valM       in   DATA_W  memory read result
//  W_dstE       in   4       E destination reg ID, 4'hF = RNONE
//  W_dstM       in   4       M destination reg ID, 4'hF = RNONE
//  W_Cnd        in   1       condition flag (gates cmovXX write)
//  d_srcA       in   4       decode read port A reg ID
//  d_srcB       in   4       decode read port B reg ID
//  d_rvalA      out  DATA_W  contents of d_srcA (0 if RNONE)
//  d_rvalB      out  DATA_W  contents of d_srcB (0 if RNONE)
//  prog_stat    out  3       latched processor status
//  prog_halt    out  1       1 once the core has stopped
//  retired_cnt  out  CNT_W   number of instructions committed with AOK
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - R0..R14 = 0; prog_stat = AOK; prog_halt = 0; retired_cnt = 0; state = RUN.
//   - Reset asserted mid-operation clears everything immediately.
//   - A write that would occur on the same edge is lost.
//  States
//   - RUN: accepts commits.
//   - STOP: absorbing until reset; no reg writes, counter frozen, prog_stat held.
//  Transition, on a posedge in RUN:
//   - W_stat in {HLT,ADR,INS}: -> STOP; prog_stat <= W_stat; prog_halt <= 1.
//   - The faulting/halting instruction writes no register and is not counted.
//  Other W_stat values, in RUN:
//   - BUB (0) and undefined codes (5..7): no write, no count, no state change.
//   - AOK: commit, as follows.
//     - writeE = (W_dstE != F) && (W_icode != 4'h2 || W_Cnd); R[W_dstE] <= W_valE.
//     - writeM = (W_dstM != F); R[W_dstM] <= W_valM.
//     - writeE && writeM to the same ID: valM wins (popq %rsp semantics).
//     - retired_cnt += 1; wraps modulo 2^CNT_W.
//  Read ports
//   - Combinational, no write-through bypass: a read in the commit cycle returns
//     pre-edge contents (decode forwarding covers W).
//   - srcX = F returns 0.
//  Latency: write visible on read ports the cycle after the commit edge.
// STRUCTURE
//  Package y86_pkg holds:
//   - stat codes: STAT_BUB, STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS
//   - icodes: I_HALT..I_POPQ, I_RRMOVQ = 4'h2
//   - RNONE = 4'hF
//   - state enum RUN/STOP
//  Sub-module regfile_2r2w:
//   - 15x DATA_W array, 2 async read ports, 2 write ports with M-over-E priority,
//     async reset.
//  Top level holds:
//   - stat FSM, write-enable decode, retired counter.
// TESTING
//  1. Reset then AOK irmovq (icode 3, dstE=0, valE=0x10, dstM=F)
//     -> next cycle d_srcA=0 reads 0x10; retired_cnt=1.
//  2. Same-ID collision: AOK popq, dstE=4 valE=0x108, dstM=4 valM=0xAA
//     -> R4=0xAA. Also: read in the commit cycle returns the old value.
//  3. cmov (icode 2, dstE=3, valE=5):
//     - W_Cnd=0 -> R3 unchanged, counter still +1.
//     - W_Cnd=1 -> R3=5.
//  4. Stop: W_stat=ADR with dstE=1
//     -> R1 untouched, prog_stat=3, prog_halt=1, counter unchanged;
//        later AOK writes ignored.
//  5. Bubble and undefined: W_stat=0 and W_stat=6 with dstE=2 valE=7
//     -> no write, no count, still RUN.
//  6. Async reset: rst_n low mid-cycle after HLT
//     -> all regs 0, prog_stat=AOK, prog_halt=0 without waiting for clk;
//        CNT_W=4 wrap 15 -> 0 on the next AOK.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes, register IDs and write-back state type
package y86_pkg;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         NUM_REGS = 15;

    typedef enum logic {RUN, STOP} state_e;

    function automatic logic is_stop_stat(input logic [2:0] stat);
        return stat == STAT_HLT || stat == STAT_ADR || stat == STAT_INS;
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// regfile_2r2w: 15-entry register file, two async read ports, two write ports with M over E
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] rval_a,
    output logic [DATA_W-1:0] rval_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // M port checked first so popq %rsp leaves the loaded value
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            regs_d[i] = (we_m && dst_m == 4'(i)) ? val_m :
                        (we_e && dst_e == 4'(i)) ? val_e : regs_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        else
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end

    assign rval_a = (src_a == RNONE) ? '0 : regs_q[src_a];
    assign rval_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 write-back stage, register file, status latch and retire counter
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic              W_Cnd,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic [2:0]        prog_stat,
    output logic              prog_halt,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_e           state_q, state_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run, aok, stop, we_e, we_m;

    // Bubbles and undefined status codes fall through as no-ops
    always_comb begin
        run     = state_q == RUN;
        aok     = run && W_stat == STAT_AOK;
        stop    = run && is_stop_stat(W_stat);
        we_e    = aok && W_dstE != RNONE && (W_icode != I_RRMOVQ || W_Cnd);
        we_m    = aok && W_dstM != RNONE;
        state_d = stop ? STOP : state_q;
        stat_d  = stop ? W_stat : stat_q;
        cnt_d   = aok ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    regfile_2r2w #(.DATA_W(DATA_W)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (we_e),
        .dst_e  (W_dstE),
        .val_e  (W_valE),
        .we_m   (we_m),
        .dst_m  (W_dstM),
        .val_m  (W_valM),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB)
    );

    assign prog_stat   = stat_q;
    assign prog_halt   = state_q == STOP;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed vectors for writeback_regfile with a 4-bit retire counter
module tb_writeback_regfile;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    W_stat;
    logic [3:0]    W_icode;
    logic [DW-1:0] W_valE, W_valM;
    logic [3:0]    W_dstE, W_dstM;
    logic          W_Cnd;
    logic [3:0]    d_srcA, d_srcB;
    logic [DW-1:0] d_rvalA, d_rvalB;
    logic [2:0]    prog_stat;
    logic          prog_halt;
    logic [CW-1:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    writeback_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .W_stat      (W_stat),
        .W_icode     (W_icode),
        .W_valE      (W_valE),
        .W_valM      (W_valM),
        .W_dstE      (W_dstE),
        .W_dstM      (W_dstM),
        .W_Cnd       (W_Cnd),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .d_rvalA     (d_rvalA),
        .d_rvalB     (d_rvalB),
        .prog_stat   (prog_stat),
        .prog_halt   (prog_halt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        W_stat = 3'd0; W_icode = 4'h1; W_valE = '0; W_valM = '0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_Cnd = 1'b0;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                         input logic cnd);
        W_stat = st; W_icode = ic; W_dstE = de; W_valE = ve;
        W_dstM = dm; W_valM = vm; W_Cnd = cnd;
    endtask

    task automatic commit(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                          input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                          input logic cnd);
        drive(st, ic, de, ve, dm, vm, cnd);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input string tag, input logic [3:0] r, input logic [63:0] exp);
        d_srcA = r; #1;
        check(tag, d_rvalA, exp);
    endtask

    initial begin
        idle();
        d_srcA = 4'hF; d_srcB = 4'hF;
        rst_n = 1'b0;
        #12;
        check("rst_stat", prog_stat, 3'd1);
        check("rst_halt", prog_halt, 1'b0);
        check("rst_cnt", retired_cnt, 4'd0);
        rd("rst_r0", 4'd0, 64'h0);
        rd("rnone_a", 4'hF, 64'h0);
        // a commit coinciding with an edge under reset is lost
        drive(3'd1, 4'h3, 4'd5, 64'h55, 4'hF, 64'h0, 1'b0);
        @(posedge clk); #1;
        idle();
        rd("rst_lost_r5", 4'd5, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        commit(3'd1, 4'h3, 4'd0, 64'h10, 4'hF, 64'h0, 1'b0);
        rd("irmov_r0", 4'd0, 64'h10);
        check("irmov_cnt", retired_cnt, 4'd1);

        drive(3'd1, 4'hB, 4'd4, 64'h108, 4'd4, 64'hAA, 1'b0);
        d_srcB = 4'd4; #1;
        check("commit_cycle_old", d_rvalB, 64'h0);
        @(posedge clk); #1;
        idle();
        check("popq_r4_m_wins", d_rvalB, 64'hAA);
        check("popq_cnt", retired_cnt, 4'd2);
        d_srcB = 4'hF; #1;
        check("rnone_b", d_rvalB, 64'h0);

        commit(3'd1, 4'hB, 4'd4, 64'h110, 4'd6, 64'h77, 1'b0);
        rd("dual_r4", 4'd4, 64'h110);
        rd("dual_r6", 4'd6, 64'h77);

        commit(3'd1, 4'h2, 4'd3, 64'h5, 4'hF, 64'h0, 1'b0);
        rd("cmov_nc_r3", 4'd3, 64'h0);
        check("cmov_nc_cnt", retired_cnt, 4'd4);
        commit(3'd1, 4'h2, 4'd3, 64'h5, 4'hF, 64'h0, 1'b1);
        rd("cmov_c_r3", 4'd3, 64'h5);
        commit(3'd1, 4'h6, 4'd7, 64'h9, 4'hF, 64'h0, 1'b0);
        rd("opq_r7", 4'd7, 64'h9);
        check("opq_cnt", retired_cnt, 4'd6);

        commit(3'd0, 4'h3, 4'd2, 64'h7, 4'hF, 64'h0, 1'b0);
        commit(3'd6, 4'h3, 4'd2, 64'h7, 4'hF, 64'h0, 1'b0);
        rd("bub_r2", 4'd2, 64'h0);
        check("bub_cnt", retired_cnt, 4'd6);
        check("bub_halt", prog_halt, 1'b0);
        check("bub_stat", prog_stat, 3'd1);

        commit(3'd1, 4'h3, 4'd14, 64'hE, 4'hF, 64'h0, 1'b0);
        rd("r14", 4'd14, 64'hE);

        commit(3'd3, 4'h5, 4'd1, 64'h99, 4'hF, 64'h0, 1'b0);
        rd("adr_r1", 4'd1, 64'h0);
        check("adr_stat", prog_stat, 3'd3);
        check("adr_halt", prog_halt, 1'b1);
        check("adr_cnt", retired_cnt, 4'd7);
        commit(3'd1, 4'h3, 4'd1, 64'h55, 4'hF, 64'h0, 1'b0);
        commit(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0);
        rd("stop_r1", 4'd1, 64'h0);
        check("stop_cnt", retired_cnt, 4'd7);
        check("stop_stat", prog_stat, 3'd3);

        @(negedge clk); rst_n = 1'b0; #1;
        rd("arst1_r4", 4'd4, 64'h0);
        check("arst1_cnt", retired_cnt, 4'd0);
        check("arst1_stat", prog_stat, 3'd1);
        @(negedge clk); rst_n = 1'b1;

        commit(3'd1, 4'h3, 4'd0, 64'h21, 4'hF, 64'h0, 1'b0);
        commit(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0);
        check("hlt_stat", prog_stat, 3'd2);
        check("hlt_halt", prog_halt, 1'b1);
        rd("hlt_r0", 4'd0, 64'h21);
        #2; rst_n = 1'b0; #1;
        rd("arst2_r0", 4'd0, 64'h0);
        check("arst2_stat", prog_stat, 3'd1);
        check("arst2_halt", prog_halt, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 15; i++) commit(3'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0);
        check("cnt_15", retired_cnt, 4'd15);
        commit(3'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0);
        check("cnt_wrap", retired_cnt, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
